multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 34 +++
 rtl/multicycle_ctrl_if.sv | 10 +
 rtl/multicycle_ctrl_main_decoder.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 132 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle control path: opcodes, FSM states,
// instruction classes and the datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW  = 6'h23,
                         OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR  = 6'h08, FN_ADDU = 6'h21,
                         FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR  = 6'h25, FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

  typedef enum logic [3:0] {
    CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_JR, CL_ILL
  } iclass_e;

  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_SHAMT = 2'd2, EXT_UPPER = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7;

  localparam logic [1:0] PC_SEQ = 2'd0, PC_BR  = 2'd1, PC_JMP = 2'd2, PC_JR = 2'd3;
  localparam logic [1:0] RD_RT  = 2'd0, RD_RD  = 2'd1, RD_RA  = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;

  typedef struct packed {
    iclass_e    cls;
    logic [1:0] ext_sel;
    logic [3:0] alu_op;
    logic       alu_src_b;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port: controller (master) raises req and holds it until ack.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel_d;
  logic mem_ack;

  modport master (output mem_req, mem_we, mem_sel_d, input mem_ack);
  modport slave  (input mem_req, mem_we, mem_sel_d, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_main_decoder.sv
// Combinational opcode/funct decode into instruction class and ALU/extender controls.
module main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '{cls: CL_ILL, ext_sel: EXT_ZERO, alu_op: ALU_ADD, alu_src_b: 1'b0, illegal: 1'b0};
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.cls = CL_RALU;
        case (i_funct)
          FN_ADDU: o_dec.alu_op = ALU_ADD;
          FN_SUBU: o_dec.alu_op = ALU_SUB;
          FN_AND:  o_dec.alu_op = ALU_AND;
          FN_OR:   o_dec.alu_op = ALU_OR;
          FN_SLT:  o_dec.alu_op = ALU_SLT;
          // shifts take shamt through the extender on the B operand
          FN_SLL: begin o_dec.alu_op = ALU_SLL; o_dec.ext_sel = EXT_SHAMT; o_dec.alu_src_b = 1'b1; end
          FN_SRL: begin o_dec.alu_op = ALU_SRL; o_dec.ext_sel = EXT_SHAMT; o_dec.alu_src_b = 1'b1; end
          FN_JR:   o_dec.cls = CL_JR;
          default: o_dec.cls = CL_ILL;
        endcase
      end
      OP_ORI:   begin o_dec.cls = CL_IALU; o_dec.alu_op = ALU_OR;  o_dec.alu_src_b = 1'b1; end
      OP_ADDIU: begin o_dec.cls = CL_IALU; o_dec.ext_sel = EXT_SIGN;  o_dec.alu_src_b = 1'b1; end
      OP_LUI:   begin o_dec.cls = CL_IALU; o_dec.ext_sel = EXT_UPPER; o_dec.alu_op = ALU_LUI;
                      o_dec.alu_src_b = 1'b1; end
      OP_LW:    begin o_dec.cls = CL_LW;   o_dec.ext_sel = EXT_SIGN;  o_dec.alu_src_b = 1'b1; end
      OP_SW:    begin o_dec.cls = CL_SW;   o_dec.ext_sel = EXT_SIGN;  o_dec.alu_src_b = 1'b1; end
      OP_BEQ:   begin o_dec.cls = CL_BEQ;  o_dec.ext_sel = EXT_SIGN;  o_dec.alu_op = ALU_SUB; end
      OP_J:     o_dec.cls = CL_J;
      OP_JAL:   o_dec.cls = CL_JAL;
      default:  o_dec.cls = CL_ILL;
    endcase
    o_dec.illegal = (o_dec.cls == CL_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: fetch/decode/exec/mem/wb sequencing with a
// req/ack memory port and an optional wait-cycle timeout.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic              i_alu_zero,
  multicycle_ctrl_if.master mem,
  output logic              o_ir_we,
  output logic              o_pc_we,
  output logic [1:0]        o_pc_src,
  output logic [1:0]        o_ext_sel,
  output logic              o_alu_src_b,
  output logic [3:0]        o_alu_op,
  output logic              o_reg_we,
  output logic [1:0]        o_reg_dst,
  output logic [1:0]        o_wb_src,
  output logic              o_instr_done,
  output logic              o_illegal,
  output logic              o_bus_err
);

  localparam logic [15:0] TMO_LAST = 16'(FETCH_TIMEOUT - 1);

  state_e      r_state, w_nxt;
  logic [15:0] r_wait;
  logic        r_mem_req, r_mem_we, r_mem_sel_d, r_pc_we, r_reg_we, r_done;
  logic [1:0]  r_pc_src, r_reg_dst, r_wb_src;
  dec_t        w_dec;
  logic        w_ack, w_in_wait, w_tmo, w_ctx, w_ir_we, w_illegal;

  main_decoder u_dec (.i_opcode(i_opcode), .i_funct(i_funct), .o_dec(w_dec));

  assign w_ack     = mem.mem_ack;
  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);
  // timeout fires on the FETCH_TIMEOUT-th consecutive cycle without ack
  assign w_tmo     = (FETCH_TIMEOUT != 0) && w_in_wait && !w_ack && (r_wait == TMO_LAST);
  assign w_ctx     = r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB};
  assign w_ir_we   = (r_state == S_FETCH) && w_ack;
  assign w_illegal = (r_state == S_DECODE) && w_dec.illegal;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_RESET:  w_nxt = S_FETCH;
      S_FETCH:  if (w_ack) w_nxt = S_DECODE;
      S_DECODE: w_nxt = w_dec.illegal ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (w_dec.cls)
          CL_RALU, CL_IALU: w_nxt = S_WB;
          CL_LW, CL_SW:     w_nxt = S_MEM;
          default:          w_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (w_ack)      w_nxt = (w_dec.cls == CL_LW) ? S_WB : S_FETCH;
        else if (w_tmo) w_nxt = S_FETCH;
      end
      S_WB:     w_nxt = S_FETCH;
      default:  w_nxt = S_RESET;
    endcase
  end

  // Static per-state outputs are registered from the next state; ack- and
  // flag-qualified strobes are combined combinationally below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET;
      r_wait      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_sel_d <= 1'b0;
      r_pc_we     <= 1'b0;
      r_pc_src    <= PC_SEQ;
      r_reg_we    <= 1'b0;
      r_reg_dst   <= RD_RT;
      r_wb_src    <= WB_ALU;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_wait      <= (w_in_wait && !w_ack && !w_tmo) ? r_wait + 16'd1 : '0;
      r_mem_req   <= (w_nxt == S_FETCH) || (w_nxt == S_MEM);
      r_mem_sel_d <= (w_nxt == S_MEM);
      r_mem_we    <= (w_nxt == S_MEM) && (w_dec.cls == CL_SW);
      r_pc_we     <= (w_nxt == S_EXEC) && (w_dec.cls inside {CL_J, CL_JAL, CL_JR});
      r_reg_we    <= (w_nxt == S_WB) || ((w_nxt == S_EXEC) && (w_dec.cls == CL_JAL));
      r_done      <= (w_nxt == S_WB) ||
                     ((w_nxt == S_EXEC) && (w_dec.cls inside {CL_BEQ, CL_J, CL_JAL, CL_JR}));
      r_pc_src    <= PC_SEQ;
      r_reg_dst   <= RD_RT;
      r_wb_src    <= WB_ALU;
      if (w_nxt == S_EXEC) begin
        case (w_dec.cls)
          CL_BEQ: r_pc_src <= PC_BR;
          CL_J:   r_pc_src <= PC_JMP;
          CL_JAL: begin r_pc_src <= PC_JMP; r_reg_dst <= RD_RA; r_wb_src <= WB_PC4; end
          CL_JR:  r_pc_src <= PC_JR;
          default: ;
        endcase
      end
      if (w_nxt == S_WB) begin
        r_reg_dst <= (w_dec.cls == CL_RALU) ? RD_RD : RD_RT;
        r_wb_src  <= (w_dec.cls == CL_LW) ? WB_MEM : WB_ALU;
      end
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_sel_d = r_mem_sel_d;

  assign o_ir_we      = w_ir_we;
  assign o_pc_we      = r_pc_we || w_ir_we ||
                        ((r_state == S_EXEC) && (w_dec.cls == CL_BEQ) && i_alu_zero);
  assign o_pc_src     = r_pc_src;
  assign o_ext_sel    = w_ctx ? w_dec.ext_sel : EXT_ZERO;
  assign o_alu_op     = w_ctx ? w_dec.alu_op : ALU_ADD;
  assign o_alu_src_b  = w_ctx && w_dec.alu_src_b;
  assign o_reg_we     = r_reg_we;
  assign o_reg_dst    = r_reg_dst;
  assign o_wb_src     = r_wb_src;
  assign o_illegal    = w_illegal;
  assign o_bus_err    = w_tmo;
  assign o_instr_done = r_done || w_illegal || w_tmo ||
                        ((r_state == S_MEM) && w_ack && (w_dec.cls == CL_SW));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: per-instruction expected output traces are generated from
// the instruction's class and the memory wait pattern, then compared per cycle.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode = '0, funct = '0;
  logic       alu_zero = 1'b0;
  logic       ir_we, pc_we, alu_src_b, reg_we, instr_done, illegal, bus_err;
  logic [1:0] pc_src, ext_sel, reg_dst, wb_src;
  logic [3:0] alu_op;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.FETCH_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_funct(funct), .i_alu_zero(alu_zero),
    .mem(bus), .o_ir_we(ir_we), .o_pc_we(pc_we), .o_pc_src(pc_src), .o_ext_sel(ext_sel),
    .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_reg_we(reg_we), .o_reg_dst(reg_dst),
    .o_wb_src(wb_src), .o_instr_done(instr_done), .o_illegal(illegal), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef enum {K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_e;

  typedef struct packed {
    logic       mem_req, mem_we, mem_sel_d, ir_we, pc_we;
    logic [1:0] pc_src, ext_sel;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       reg_we;
    logic [1:0] reg_dst, wb_src;
    logic       done, illegal, bus_err;
  } ov_t;

  typedef struct {
    string name; logic [5:0] op, fn; kind_e kind;
    logic [1:0] ext; logic [3:0] alu; logic srcb; bit dc;
  } ins_t;

  typedef struct { ov_t e; ov_t m; bit ack; bit z; } cyc_t;

  ins_t tbl[$];
  cyc_t q[$];
  int   n_err = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ov_t obs();
    ov_t o;
    o.mem_req = bus.mem_req; o.mem_we = bus.mem_we; o.mem_sel_d = bus.mem_sel_d;
    o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.ext_sel = ext_sel;
    o.alu_src_b = alu_src_b; o.alu_op = alu_op; o.reg_we = reg_we; o.reg_dst = reg_dst;
    o.wb_src = wb_src; o.done = instr_done; o.illegal = illegal; o.bus_err = bus_err;
    return o;
  endfunction

  function automatic void add_ins(string nm, logic [5:0] op, logic [5:0] fn, kind_e k,
                                  logic [1:0] ext, logic [3:0] alu, logic srcb, bit dc);
    ins_t t;
    t.name = nm; t.op = op; t.fn = fn; t.kind = k; t.ext = ext; t.alu = alu; t.srcb = srcb; t.dc = dc;
    tbl.push_back(t);
  endfunction

  function automatic int find(string nm);
    foreach (tbl[i]) if (tbl[i].name == nm) return i;
    return 0;
  endfunction

  function automatic void push_c(ov_t e, ov_t m, bit ack, bit z);
    cyc_t c;
    c.e = e; c.m = m; c.ack = ack; c.z = z;
    q.push_back(c);
  endfunction

  // Expected trace: fetch (wf waits), decode, exec, optional mem (wm waits), optional wb.
  task automatic build(input int k, input int wf, input int wm, input bit z, input bit tf, input bit tm);
    kind_e kd = tbl[k].kind;
    ov_t   de = '0, dm = '1, fm = '1, e;
    bit    zz;
    int    n;
    q.delete();
    de.ext_sel = tbl[k].ext; de.alu_op = tbl[k].alu; de.alu_src_b = tbl[k].srcb;
    if (tbl[k].dc) begin dm.alu_op = '0; dm.alu_src_b = 1'b0; end
    fm.ext_sel = '0; fm.alu_op = '0; fm.alu_src_b = 1'b0;
    if (tf) begin
      for (int c = 0; c < T; c++) begin
        e = '0; e.mem_req = 1'b1;
        if (c == T-1) begin e.bus_err = 1'b1; e.done = 1'b1; end
        push_c(e, fm, 1'b0, rb());
      end
      return;
    end
    for (int c = 0; c <= wf; c++) begin
      e = '0; e.mem_req = 1'b1;
      if (c == wf) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      push_c(e, fm, c == wf, rb());
    end
    e = de;
    if (kd == K_ILL) begin e.illegal = 1'b1; e.done = 1'b1; end
    push_c(e, dm, rb(), rb());
    if (kd == K_ILL) return;
    e = de; zz = rb();
    case (kd)
      K_BEQ: begin e.pc_we = z; e.pc_src = 2'd1; e.done = 1'b1; zz = z; end
      K_J:   begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.done = 1'b1; end
      K_JAL: begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.done = 1'b1;
                   e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_src = 2'd2; end
      K_JR:  begin e.pc_we = 1'b1; e.pc_src = 2'd3; e.done = 1'b1; end
      default: ;
    endcase
    push_c(e, dm, rb(), zz);
    if (kd inside {K_BEQ, K_J, K_JAL, K_JR}) return;
    if (kd == K_LW || kd == K_SW) begin
      n = tm ? T : wm + 1;
      for (int c = 0; c < n; c++) begin
        bit a = 1'b0;
        e = de; e.mem_req = 1'b1; e.mem_sel_d = 1'b1; e.mem_we = (kd == K_SW);
        if (tm) begin
          if (c == T-1) begin e.bus_err = 1'b1; e.done = 1'b1; end
        end else if (c == wm) begin
          a = 1'b1; e.done = (kd == K_SW);
        end
        push_c(e, dm, a, rb());
      end
      if (tm || kd == K_SW) return;
    end
    e = de; e.reg_we = 1'b1; e.done = 1'b1;
    e.reg_dst = (kd == K_RALU) ? 2'd1 : 2'd0;
    e.wb_src  = (kd == K_LW) ? 2'd1 : 2'd0;
    push_c(e, dm, rb(), rb());
  endtask

  task automatic run(input int k, input int limit, output int dcyc);
    ov_t o;
    dcyc = -1;
    for (int i = 0; i < q.size() && i < limit; i++) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = tbl[k].op;
        funct  = (tbl[k].op == 6'h00) ? tbl[k].fn : 6'($urandom);
      end
      bus.mem_ack = q[i].ack;
      alu_zero    = q[i].z;
      #1;
      o = obs();
      chk($sformatf("%s_c%0d", tbl[k].name, i), 32'(o & q[i].m), 32'(q[i].e & q[i].m));
      if (o.done && dcyc < 0) dcyc = i + 1;
    end
  endtask

  function automatic int base_cyc(kind_e kd);
    case (kd)
      K_LW:                      return 5;
      K_RALU, K_IALU, K_SW:      return 4;
      K_BEQ, K_J, K_JAL, K_JR:   return 3;
      default:                   return 2;
    endcase
  endfunction

  task automatic do_ins(input int k, input int wf, input int wm, input bit z);
    int d, x;
    build(k, wf, wm, z, 1'b0, 1'b0);
    run(k, 1000, d);
    x = base_cyc(tbl[k].kind) + wf + ((tbl[k].kind inside {K_LW, K_SW}) ? wm : 0);
    chk($sformatf("%s_cycles", tbl[k].name), 32'(d), 32'(x));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    add_ins("addu", 6'h00, 6'h21, K_RALU, 2'd0, ALU_ADD, 1'b0, 1'b0);
    add_ins("subu", 6'h00, 6'h23, K_RALU, 2'd0, ALU_SUB, 1'b0, 1'b0);
    add_ins("and",  6'h00, 6'h24, K_RALU, 2'd0, ALU_AND, 1'b0, 1'b0);
    add_ins("or",   6'h00, 6'h25, K_RALU, 2'd0, ALU_OR,  1'b0, 1'b0);
    add_ins("slt",  6'h00, 6'h2A, K_RALU, 2'd0, ALU_SLT, 1'b0, 1'b0);
    add_ins("sll",  6'h00, 6'h00, K_RALU, 2'd2, ALU_SLL, 1'b1, 1'b0);
    add_ins("srl",  6'h00, 6'h02, K_RALU, 2'd2, ALU_SRL, 1'b1, 1'b0);
    add_ins("jr",   6'h00, 6'h08, K_JR,   2'd0, 4'd0,    1'b0, 1'b1);
    add_ins("ori",  6'h0D, 6'h00, K_IALU, 2'd0, ALU_OR,  1'b1, 1'b0);
    add_ins("addiu",6'h09, 6'h00, K_IALU, 2'd1, ALU_ADD, 1'b1, 1'b0);
    add_ins("lui",  6'h0F, 6'h00, K_IALU, 2'd3, ALU_LUI, 1'b1, 1'b0);
    add_ins("lw",   6'h23, 6'h00, K_LW,   2'd1, ALU_ADD, 1'b1, 1'b0);
    add_ins("sw",   6'h2B, 6'h00, K_SW,   2'd1, ALU_ADD, 1'b1, 1'b0);
    add_ins("beq",  6'h04, 6'h00, K_BEQ,  2'd1, ALU_SUB, 1'b0, 1'b0);
    add_ins("j",    6'h02, 6'h00, K_J,    2'd0, 4'd0,    1'b0, 1'b1);
    add_ins("jal",  6'h03, 6'h00, K_JAL,  2'd0, 4'd0,    1'b0, 1'b1);
    add_ins("ill_fn3f", 6'h00, 6'h3F, K_ILL, 2'd0, 4'd0, 1'b0, 1'b1);
    add_ins("ill_fn20", 6'h00, 6'h20, K_ILL, 2'd0, 4'd0, 1'b0, 1'b1);
    add_ins("ill_op3f", 6'h3F, 6'h00, K_ILL, 2'd0, 4'd0, 1'b0, 1'b1);
    add_ins("ill_op01", 6'h01, 6'h00, K_ILL, 2'd0, 4'd0, 1'b0, 1'b1);

    // reset held with ack tied high: everything quiet
    rst_n = 1'b1; bus.mem_ack = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) begin @(negedge clk); #1; chk("reset", 32'(obs()), 32'd0); end
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_cycle1", 32'(obs()), 32'd0);

    do_ins(find("lui"), 0, 0, 1'b0);
    do_ins(find("lw"), 2, 2, 1'b0);
    do_ins(find("beq"), 0, 0, 1'b0);
    do_ins(find("beq"), 0, 0, 1'b1);
    do_ins(find("sll"), 0, 0, 1'b0);
    do_ins(find("ill_fn3f"), 0, 0, 1'b0);

    // fetch timeout, then memory-stage timeout on a load
    build(find("addu"), 0, 0, 1'b0, 1'b1, 1'b0);
    run(find("addu"), 1000, d);
    chk("fetch_tmo_cycles", 32'(d), 32'(T));
    build(find("lw"), 1, 0, 1'b0, 1'b0, 1'b1);
    run(find("lw"), 1000, d);
    chk("mem_tmo_cycles", 32'(d), 32'(4 + T));

    // asynchronous reset while a store waits in the memory stage
    build(find("sw"), 0, 0, 1'b0, 1'b0, 1'b1);
    run(find("sw"), 5, d);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(obs()), 32'd0);
    @(negedge clk); #1;
    chk("rst_hold", 32'(obs()), 32'd0);
    rst_n = 1'b1; #1;
    chk("rst_rel2", 32'(obs()), 32'd0);

    repeat (60) begin
      do_ins($urandom_range(0, tbl.size() - 1), $urandom_range(0, T-1), $urandom_range(0, T-1), rb());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
